// File: rtl/darkrom_dp.sv
// Dual-port firmware ROM (port I = fetch, port D = .rodata loads) with base decode and range/alignment errors.
// Latency: LATENCY cycles per port (one BRAM read plus LATENCY-1 output registers); one request per cycle per port.
// Backpressure: i_hold/d_hold freeze that port's whole pipeline and outputs; requests presented during hold are dropped.
//
// Ports: XCLK/XRES clock and async active-low reset; per port (i_, d_):
//   *_req/*_addr request and byte address, *_hold stall, *_data/*_valid/*_err result.
//   A miss returns err=1 with FILL on port I and zero on port D; an empty slot returns valid=0, err=0 and the same idle word.
module darkrom_dp #(
  parameter int              AW        = 32,
  parameter int              DW        = 32,
  parameter int              DEPTH     = 512,
  parameter logic [AW-1:0]   BASE      = '0,
  parameter int              LATENCY   = 1,
  parameter string           INIT_FILE = "firmware.mem",
  parameter logic [DW-1:0]   FILL      = 32'h0000_0013
) (
  input  logic          XCLK,
  input  logic          XRES,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_hold,
  output logic [DW-1:0] i_data,
  output logic          i_valid,
  output logic          i_err,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic          d_hold,
  output logic [DW-1:0] d_data,
  output logic          d_valid,
  output logic          d_err
);

  localparam int            SH    = $clog2(DW / 8);
  localparam int            IW    = $clog2(DEPTH);
  localparam logic [AW-1:0] AMASK = AW'(DW / 8 - 1);

  if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
    $error("darkrom_dp: LATENCY must be in 1..3");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("darkrom_dp: DEPTH must be a power of 2 and >= 2");
  end
  if ((BASE & AMASK) != '0) begin : g_bad_base
    $error("darkrom_dp: BASE must be word aligned");
  end

  logic [DW-1:0] rom [DEPTH];

  // Array preload: every word starts as FILL. The array is never written after this.
  initial begin
    for (int k = 0; k < DEPTH; k++) rom[k] = FILL;
  end

  // Port 0 = I, port 1 = D; both run the identical pipeline, only the idle word differs.
  logic [1:0]          req, hold, ov, oe;
  logic [1:0][AW-1:0]  addr;
  logic [1:0][DW-1:0]  od;

  assign req  = {d_req, i_req};
  assign hold = {d_hold, i_hold};
  assign addr = {d_addr, i_addr};

  assign i_valid = ov[0];
  assign i_err   = oe[0];
  assign i_data  = od[0];
  assign d_valid = ov[1];
  assign d_err   = oe[1];
  assign d_data  = od[1];

  for (genvar p = 0; p < 2; p++) begin : g_port
    localparam logic [DW-1:0] IDLE = (p == 0) ? FILL : '0;

    logic [AW-1:0] off;
    logic          hit;
    logic [IW-1:0] ridx;
    logic          v0, e0;
    logic [DW-1:0] rdat, d0;

    // addr >= BASE rejects anything below the window, so a window that
    // runs past 2^AW never aliases wrapped low addresses onto the ROM.
    always_comb begin
      off  = addr[p] - BASE;
      hit  = (addr[p] >= BASE) && ((off >> SH) < AW'(DEPTH)) && ((addr[p] & AMASK) == '0);
      ridx = IW'(off >> SH);
    end

    // Stage 0 control: valid and miss flag captured on the accepting edge.
    always_ff @(posedge XCLK or negedge XRES) begin
      if (!XRES) begin
        v0 <= 1'b0;
        e0 <= 1'b0;
      end else if (!hold[p]) begin
        v0 <= req[p];
        e0 <= req[p] & ~hit;
      end
    end

    // BRAM read port; hold acts as the read enable so the output register freezes.
    always_ff @(posedge XCLK) begin
      if (!hold[p]) rdat <= rom[ridx];
    end

    // rdat has no reset, so it is masked whenever the slot is empty or a miss.
    assign d0 = (v0 && !e0) ? rdat : IDLE;

    if (LATENCY == 1) begin : g_lat1
      assign ov[p] = v0;
      assign oe[p] = e0;
      assign od[p] = d0;
    end else begin : g_latn
      logic          vq [LATENCY-1];
      logic          eq [LATENCY-1];
      logic [DW-1:0] dq [LATENCY-1];

      always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
          for (int s = 0; s < LATENCY - 1; s++) begin
            vq[s] <= 1'b0;
            eq[s] <= 1'b0;
            dq[s] <= IDLE;
          end
        end else if (!hold[p]) begin
          vq[0] <= v0;
          eq[0] <= e0;
          dq[0] <= d0;
          for (int s = 1; s < LATENCY - 1; s++) begin
            vq[s] <= vq[s-1];
            eq[s] <= eq[s-1];
            dq[s] <= dq[s-1];
          end
        end
      end

      assign ov[p] = vq[LATENCY-2];
      assign oe[p] = eq[LATENCY-2];
      assign od[p] = dq[LATENCY-2];
    end
  end

endmodule

// File: tb/tb_darkrom_dp.sv
// Bench for darkrom_dp: two instances share one stimulus stream.
// Instance A: LATENCY=1, BASE=0. Instance B: LATENCY=3, BASE=0x1000. Image w[k] = k*0x1111 in both.
module tb_darkrom_dp;

  logic        XCLK = 1'b0;
  logic        XRES = 1'b0;
  logic        i_req = 1'b0, i_hold = 1'b0, d_req = 1'b0, d_hold = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0;

  logic [31:0] a_i_data, a_d_data, b_i_data, b_d_data;
  logic        a_i_valid, a_i_err, a_d_valid, a_d_err;
  logic        b_i_valid, b_i_err, b_d_valid, b_d_err;

  always #5 XCLK = ~XCLK;

  darkrom_dp #(.AW(32), .DW(32), .DEPTH(512), .BASE(32'h0000_0000), .LATENCY(1),
               .INIT_FILE(""), .FILL(32'h0000_0013)) dut_a (
    .XCLK(XCLK), .XRES(XRES),
    .i_req(i_req), .i_addr(i_addr), .i_hold(i_hold),
    .i_data(a_i_data), .i_valid(a_i_valid), .i_err(a_i_err),
    .d_req(d_req), .d_addr(d_addr), .d_hold(d_hold),
    .d_data(a_d_data), .d_valid(a_d_valid), .d_err(a_d_err));

  darkrom_dp #(.AW(32), .DW(32), .DEPTH(512), .BASE(32'h0000_1000), .LATENCY(3),
               .INIT_FILE(""), .FILL(32'h0000_0013)) dut_b (
    .XCLK(XCLK), .XRES(XRES),
    .i_req(i_req), .i_addr(i_addr), .i_hold(i_hold),
    .i_data(b_i_data), .i_valid(b_i_valid), .i_err(b_i_err),
    .d_req(d_req), .d_addr(d_addr), .d_hold(d_hold),
    .d_data(b_d_data), .d_valid(b_d_valid), .d_err(b_d_err));

  typedef struct {
    logic        err;
    logic [31:0] dat;
    int          due;
  } exp_t;

  localparam int          LAT [2] = '{1, 3};
  localparam logic [31:0] BAS [2] = '{32'h0000_0000, 32'h0000_1000};

  // Stream q = instance*2 + port (port 0 = I, port 1 = D).
  exp_t        sb [4][$];
  int          adv  [2] = '{0, 0};
  logic        advd [2] = '{1'b0, 1'b0};
  logic [31:0] od [4], pd [4];
  logic        ov [4], oe [4], pv [4], pe [4];
  int          nchk = 0, nerr = 0;

  always_comb begin
    od[0] = a_i_data; ov[0] = a_i_valid; oe[0] = a_i_err;
    od[1] = a_d_data; ov[1] = a_d_valid; oe[1] = a_d_err;
    od[2] = b_i_data; ov[2] = b_i_valid; oe[2] = b_i_err;
    od[3] = b_d_data; ov[3] = b_d_valid; oe[3] = b_d_err;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input int k, input int p, input logic [31:0] a);
    exp_t        e;
    logic [31:0] off;
    logic        hit;
    off   = a - BAS[k];
    hit   = (a >= BAS[k]) && ((off / 4) < 512) && (a[1:0] == 2'b00);
    e.err = !hit;
    e.dat = hit ? (off / 4) * 32'h1111 : ((p == 0) ? 32'h0000_0013 : 32'h0);
    e.due = 0;
    return e;
  endfunction

  // Acceptance side of the scoreboard: every hold=0 edge advances that port,
  // and an accepted request is due LATENCY-1 advancing edges later.
  always @(posedge XCLK) begin
    for (int p = 0; p < 2; p++) begin
      logic        h, r;
      logic [31:0] a;
      exp_t        e;
      h = (p == 0) ? i_hold : d_hold;
      r = (p == 0) ? i_req  : d_req;
      a = (p == 0) ? i_addr : d_addr;
      advd[p] = XRES && !h;
      if (advd[p]) begin
        adv[p]++;
        if (r) begin
          for (int k = 0; k < 2; k++) begin
            e     = model(k, p, a);
            e.due = adv[p] + LAT[k] - 1;
            sb[k*2+p].push_back(e);
          end
        end
      end
    end
  end

  // Output side: compare away from the active edge.
  always @(negedge XCLK) begin
    for (int q = 0; q < 4; q++) begin
      int   p;
      logic ev;
      exp_t e;
      p = q % 2;
      if (XRES) begin
        if (!advd[p]) begin
          chk($sformatf("hold_valid[%0d]", q), ov[q], pv[q]);
          chk($sformatf("hold_err[%0d]", q), oe[q], pe[q]);
          chk($sformatf("hold_data[%0d]", q), od[q], pd[q]);
        end else begin
          ev = (sb[q].size() > 0) && (sb[q][0].due == adv[p]);
          chk($sformatf("valid[%0d]", q), ov[q], ev);
          if (ev) begin
            e = sb[q].pop_front();
            chk($sformatf("data[%0d]", q), od[q], e.dat);
            chk($sformatf("err[%0d]", q), oe[q], e.err);
          end else begin
            chk($sformatf("idle_err[%0d]", q), oe[q], 1'b0);
            chk($sformatf("idle_data[%0d]", q), od[q], (p == 0) ? 32'h0000_0013 : 32'h0);
          end
        end
      end
      pv[q] = ov[q];
      pe[q] = oe[q];
      pd[q] = od[q];
    end
  end

  task automatic cyc(input logic ir, input logic [31:0] ia, input logic ih,
                     input logic dr, input logic [31:0] da, input logic dh);
    @(negedge XCLK);
    #1;
    i_req = ir; i_addr = ia; i_hold = ih;
    d_req = dr; d_addr = da; d_hold = dh;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Assert reset (outputs must clear at once), hold it, release just after a falling edge.
  task automatic do_reset(input int ncyc);
    @(negedge XCLK);
    #1;
    XRES = 1'b0;
    i_req = 1'b0; d_req = 1'b0; i_hold = 1'b0; d_hold = 1'b0;
    for (int q = 0; q < 4; q++) sb[q].delete();
    #1;
    for (int q = 0; q < 4; q++) begin
      chk($sformatf("rst_valid[%0d]", q), ov[q], 1'b0);
      chk($sformatf("rst_err[%0d]", q), oe[q], 1'b0);
      chk($sformatf("rst_data[%0d]", q), od[q], (q % 2 == 0) ? 32'h0000_0013 : 32'h0);
    end
    repeat (ncyc) @(negedge XCLK);
    #1;
    XRES = 1'b1;
  endtask

  initial begin
    #1;
    for (int k = 0; k < 512; k++) begin
      dut_a.rom[k] = k * 32'h1111;
      dut_b.rom[k] = k * 32'h1111;
    end
    do_reset(2);

    // Back-to-back fetches of words 0..2.
    cyc(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(4);

    // Last word in range, first word past the end.
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h7FC, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h800, 1'b0);
    idle(4);

    // Misaligned on both ports, then both ports on idx 37 in the same cycle.
    cyc(1'b1, 32'h2, 1'b0, 1'b1, 32'h2, 1'b0);
    cyc(1'b1, 32'h94, 1'b0, 1'b1, 32'h94, 1'b0);
    cyc(1'b1, 32'h1094, 1'b0, 1'b1, 32'h1094, 1'b0);
    idle(4);

    // Five-request stream on port I with a 4-cycle hold mid-stream (req toggling under
    // hold must be ignored); port D streams on through it, then takes its own hold.
    cyc(1'b1, 32'h1000, 1'b0, 1'b1, 32'h10, 1'b0);
    cyc(1'b1, 32'h1004, 1'b0, 1'b1, 32'h14, 1'b0);
    cyc(1'b1, 32'h1100, 1'b1, 1'b1, 32'h18, 1'b0);
    cyc(1'b0, 32'h1104, 1'b1, 1'b1, 32'h101C, 1'b0);
    cyc(1'b1, 32'h1108, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h110C, 1'b1, 1'b1, 32'h1020, 1'b0);
    cyc(1'b1, 32'h1008, 1'b0, 1'b1, 32'h1024, 1'b1);
    cyc(1'b1, 32'h100C, 1'b0, 1'b1, 32'h1028, 1'b1);
    cyc(1'b1, 32'h1010, 1'b0, 1'b1, 32'h102C, 1'b0);
    idle(6);

    // Random traffic across both windows, with misalignment and holds.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ia, da;
      ia = $urandom_range(0, 32'h1900);
      da = $urandom_range(0, 32'h1900);
      if ($urandom_range(0, 3) != 0) ia[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) da[1:0] = 2'b00;
      cyc($urandom_range(0, 9) < 7, ia, $urandom_range(0, 4) == 0,
          $urandom_range(0, 9) < 7, da, $urandom_range(0, 4) == 0);
    end
    idle(6);

    // Reset with requests in flight, then base-window edges; request is
    // presented right at release so it is taken on the first edge.
    cyc(1'b1, 32'h1010, 1'b0, 1'b1, 32'h20, 1'b0);
    cyc(1'b1, 32'h1014, 1'b0, 1'b1, 32'h24, 1'b0);
    do_reset(2);
    i_req = 1'b1; i_addr = 32'hFFC; d_req = 1'b1; d_addr = 32'h1000;
    cyc(1'b1, 32'h1000, 1'b0, 1'b1, 32'hFFC, 1'b0);
    cyc(1'b1, 32'h1FFC, 1'b0, 1'b1, 32'h1800, 1'b0);
    idle(8);

    for (int q = 0; q < 4; q++) chk($sformatf("drain[%0d]", q), sb[q].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
